// File: rtl/crc_stream_sequencer_if.sv
// ============================================================================
// Module      : crc_stream_sequencer_if
// Description : Byte-stream input and frame-result handshake bundle for the
//               CRC stream sequencer. The master drives bytes in and consumes
//               results; the slave (the sequencer) accepts bytes and
//               presents results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crc_stream_sequencer_if #(
    parameter int CRC_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           s_data;
    logic                 s_last;
    logic                 res_valid;
    logic                 res_ready;
    logic [CRC_WIDTH-1:0] res_crc;
    logic                 res_len_err;
    logic [CNT_WIDTH-1:0] res_words;

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, res_crc, res_len_err, res_words
    );

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, res_crc, res_len_err, res_words
    );
endinterface

`default_nettype wire

// File: rtl/crc_stream_sequencer.sv
// ============================================================================
// Module      : crc_stream_sequencer
// Description : Packs a byte stream into DATA_BYTES-wide words (first byte in
//               the most-significant lane), feeds each word to a registered
//               parallel CRC engine with the running CRC as seed, chains the
//               result, and presents the final-XORed frame CRC on a
//               valid/ready result port. Short final words are zero-padded
//               and flagged with res_len_err.
//               Optional macro CRC_SEQ_REFLECT_OUT_EN adds a reflect_out
//               input that bit-reverses the CRC before the final XOR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_stream_sequencer #(
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire                      clk,
    input  wire                      rst,
    crc_stream_sequencer_if.slave    bus,
    input  wire [CRC_WIDTH-1:0]      crc_seed,
    input  wire [CRC_WIDTH-1:0]      final_xor,
`ifdef CRC_SEQ_REFLECT_OUT_EN
    input  wire                      reflect_out,
`endif
    output logic [DATA_BYTES*8-1:0]  eng_data,
    output logic [CRC_WIDTH-1:0]     eng_crc_in,
    output logic                     eng_enable,
    input  wire [CRC_WIDTH-1:0]      eng_crc_out
);

    localparam int              CW   = $clog2(DATA_BYTES + 1);
    localparam logic [CW-1:0]   FULL = CW'(DATA_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nx;

    logic [DATA_BYTES*8-1:0] word;
    logic [DATA_BYTES*8-1:0] word_ins;
    logic [CW-1:0]           count;
    logic [CW-1:0]           fill_count;
    logic [CRC_WIDTH-1:0]    running_crc;
    logic [CRC_WIDTH-1:0]    xor_reg;
    logic [CNT_WIDTH-1:0]    words;
    logic                    last_seen;
    logic                    len_err;
    logic                    in_ready;
    logic                    accept;
    logic                    word_done;
    logic [CRC_WIDTH-1:0]    crc_final;

    logic                    res_valid;
    logic [CRC_WIDTH-1:0]    res_crc;
    logic                    res_len_err;
    logic [CNT_WIDTH-1:0]    res_words;

`ifdef CRC_SEQ_REFLECT_OUT_EN
    logic                    reflect_reg;

    function automatic logic [CRC_WIDTH-1:0] bit_reverse(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = v[CRC_WIDTH-1-i];
        end
        return r;
    endfunction
`endif

    assign in_ready      = (state == S_IDLE) || (state == S_FILL);
    assign accept        = bus.s_valid && in_ready;
    assign bus.s_ready   = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_crc   = res_crc;
    assign bus.res_len_err = res_len_err;
    assign bus.res_words = res_words;

    assign eng_data   = word;
    assign eng_crc_in = running_crc;
    assign eng_enable = (state == S_ISSUE);

    // Lane insertion: the n-th byte of a word lands in lane DATA_BYTES-n;
    // a new frame starts from an all-zero word so short words are padded.
    always_comb begin
        fill_count = (state == S_IDLE) ? CW'(1) : count + CW'(1);
        word_done  = (fill_count == FULL) || bus.s_last;
        word_ins   = (state == S_IDLE) ? '0 : word;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i == DATA_BYTES - int'(fill_count)) begin
                word_ins[i*8 +: 8] = bus.s_data;
            end
        end
`ifdef CRC_SEQ_REFLECT_OUT_EN
        crc_final = (reflect_reg ? bit_reverse(eng_crc_out) : eng_crc_out) ^ xor_reg;
`else
        crc_final = eng_crc_out ^ xor_reg;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_FILL: begin
                if (accept && word_done) begin
                    state_nx = S_ISSUE;
                end else if (accept) begin
                    state_nx = S_FILL;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  state_nx = last_seen ? S_DONE : S_FILL;
            S_DONE: begin
                if (bus.res_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: packing, CRC chaining, word count and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word        <= '0;
            count       <= '0;
            running_crc <= '0;
            xor_reg     <= '0;
            words       <= '0;
            last_seen   <= 1'b0;
            len_err     <= 1'b0;
            res_valid   <= 1'b0;
            res_crc     <= '0;
            res_len_err <= 1'b0;
            res_words   <= '0;
`ifdef CRC_SEQ_REFLECT_OUT_EN
            reflect_reg <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_FILL: begin
                    if (accept) begin
                        if (state == S_IDLE) begin
                            running_crc <= crc_seed;
                            xor_reg     <= final_xor;
                            words       <= '0;
`ifdef CRC_SEQ_REFLECT_OUT_EN
                            reflect_reg <= reflect_out;
`endif
                        end
                        word      <= word_ins;
                        count     <= fill_count;
                        last_seen <= bus.s_last;
                        if (bus.s_last && (fill_count != FULL)) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (words != '1) begin
                        words <= words + CNT_WIDTH'(1);
                    end
                end
                S_WAIT: begin
                    running_crc <= eng_crc_out;
                    if (last_seen) begin
                        res_crc     <= crc_final;
                        res_len_err <= len_err;
                        res_words   <= words;
                        res_valid   <= 1'b1;
                    end else begin
                        count <= '0;
                        word  <= '0;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        len_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crc_stream_sequencer.sv
// ============================================================================
// Module      : tb_crc_stream_sequencer
// Description : Self-checking bench for crc_stream_sequencer. Three instances
//               (DATA_BYTES = 1, 4, 8) each feed a behavioural CRC-32 engine
//               stub; frame results are compared to a byte-serial reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_stream_sequencer;

    localparam int          NI   = 3;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_valid_a [NI];
    logic [7:0]  s_data_a  [NI];
    logic        s_last_a  [NI];
    logic        res_ready_a [NI];
    logic [31:0] seed_a [NI];
    logic [31:0] fxor_a [NI];

    wire         s_ready_w   [NI];
    wire         res_valid_w [NI];
    wire [31:0]  res_crc_w   [NI];
    wire         res_err_w   [NI];
    wire [15:0]  res_words_w [NI];
    wire         eng_en_w    [NI];
    wire [31:0]  eng_cin_w   [NI];
    wire [63:0]  eng_data_w  [NI];

    logic [7:0]  frame_q [$];

    // MSB-first CRC-32 update of one byte (non-reflected).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'h0};
        for (int i = 0; i < 8; i++) begin
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    // Engine stub arithmetic: CRC over the n low bytes of d, highest byte first.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [63:0] d, input int n);
        logic [31:0] r;
        logic [63:0] t;
        r = c;
        for (int b = n - 1; b >= 0; b--) begin
            t = d >> (b * 8);
            r = crc_byte(r, t[7:0]);
        end
        return r;
    endfunction

    function automatic int db_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            localparam int DB = (k == 0) ? 1 : ((k == 1) ? 4 : 8);

            crc_stream_sequencer_if #(.CRC_WIDTH(32), .CNT_WIDTH(16)) bus ();

            logic [DB*8-1:0] eng_data;
            logic [31:0]     eng_crc_in;
            logic [31:0]     eng_crc_out;
            logic            eng_enable;

            int          issue_cnt = 0;
            int          prev_cyc  = 0;
            int          last_cyc  = 0;
            logic [31:0] last_cin  = '0;
            logic [31:0] out_at_issue = '0;
            logic [63:0] last_data = '0;

            assign bus.s_valid   = s_valid_a[k];
            assign bus.s_data    = s_data_a[k];
            assign bus.s_last    = s_last_a[k];
            assign bus.res_ready = res_ready_a[k];
            assign s_ready_w[k]   = bus.s_ready;
            assign res_valid_w[k] = bus.res_valid;
            assign res_crc_w[k]   = bus.res_crc;
            assign res_err_w[k]   = bus.res_len_err;
            assign res_words_w[k] = bus.res_words;
            assign eng_en_w[k]    = eng_enable;
            assign eng_cin_w[k]   = eng_crc_in;
            assign eng_data_w[k]  = 64'(eng_data);

            crc_stream_sequencer #(
                .DATA_BYTES(DB),
                .CRC_WIDTH (32),
                .CNT_WIDTH (16)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .bus        (bus),
                .crc_seed   (seed_a[k]),
                .final_xor  (fxor_a[k]),
`ifdef CRC_SEQ_REFLECT_OUT_EN
                .reflect_out(1'b0),
`endif
                .eng_data   (eng_data),
                .eng_crc_in (eng_crc_in),
                .eng_enable (eng_enable),
                .eng_crc_out(eng_crc_out)
            );

            // Registered parallel CRC engine stand-in.
            always @(posedge clk) begin
                if (rst) eng_crc_out <= '0;
                else if (eng_enable) eng_crc_out <= crc_word(eng_crc_in, 64'(eng_data), DB);
            end

            // Record each engine issue.
            always @(negedge clk) begin
                if (eng_enable) begin
                    issue_cnt    <= issue_cnt + 1;
                    prev_cyc     <= last_cyc;
                    last_cyc     <= cyc;
                    last_cin     <= eng_crc_in;
                    out_at_issue <= eng_crc_out;
                    last_data    <= 64'(eng_data);
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put_byte(input int k, input logic [7:0] b, input logic last);
        int guard;
        s_valid_a[k] = 1'b1;
        s_data_a[k]  = b;
        s_last_a[k]  = last;
        guard = 0;
        @(negedge clk);
        while (!s_ready_w[k] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("s_ready_timeout", 64'(s_ready_w[k]), 64'd1);
        @(posedge clk);
        #1;
        s_valid_a[k] = 1'b0;
        s_last_a[k]  = 1'b0;
    endtask

    task automatic send_frame(input int k, input logic [31:0] seed, input logic [31:0] fx, input bit gaps);
        seed_a[k] = seed;
        fxor_a[k] = fx;
        for (int i = 0; i < frame_q.size(); i++) begin
            put_byte(k, frame_q[i], i == frame_q.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_valid(input int k);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!res_valid_w[k] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("res_valid_timeout", 64'(res_valid_w[k]), 64'd1);
    endtask

    task automatic get_result(input int k, input int hold,
                              output logic [31:0] crc, output logic [15:0] w, output logic e);
        wait_valid(k);
        crc = res_crc_w[k];
        w   = res_words_w[k];
        e   = res_err_w[k];
        repeat (hold) @(negedge clk);
        res_ready_a[k] = 1'b1;
        @(posedge clk);
        #1;
        res_ready_a[k] = 1'b0;
    endtask

    // Reference: CRC over the whole byte stream, zero-padded to whole words.
    task automatic model(input int db, input logic [31:0] seed, input logic [31:0] fx,
                         output logic [31:0] crc, output logic [15:0] w, output logic e);
        int n;
        int padded;
        n      = frame_q.size();
        padded = ((n + db - 1) / db) * db;
        crc    = seed;
        for (int i = 0; i < padded; i++) begin
            crc = crc_byte(crc, (i < n) ? frame_q[i] : 8'h00);
        end
        crc = crc ^ fx;
        w   = 16'(padded / db);
        e   = (n % db) != 0;
    endtask

    task automatic check_frame(input int k, input logic [31:0] seed, input logic [31:0] fx,
                               input bit gaps, input int hold);
        logic [31:0] rc, ec;
        logic [15:0] rw, ew;
        logic        re, ee;
        send_frame(k, seed, fx, gaps);
        get_result(k, hold, rc, rw, re);
        model(db_of(k), seed, fx, ec, ew, ee);
        chk("frame_crc", 64'(rc), 64'(ec));
        chk("frame_words", 64'(rw), 64'(ew));
        chk("frame_len_err", 64'(re), 64'(ee));
    endtask

    typedef struct {
        int          inst;
        int          len;
        int          pat;
        logic [31:0] seed;
        logic [31:0] fx;
        logic        known;
        logic [31:0] exp_crc;
        logic [15:0] exp_words;
        logic        exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] rc, ec;
        logic [15:0] rw, ew;
        logic        re, ee;
        int          n0;
        int          k;
        int          len;
        logic [31:0] seed;
        logic [31:0] fx;
        logic [31:0] c;

        tbl[0] = '{0,  9, 0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h0376E6E7, 16'd9, 1'b0};
        tbl[1] = '{0,  9, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFC891918, 16'd9, 1'b0};
        tbl[2] = '{1,  5, 1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h0,        16'd2, 1'b1};
        tbl[3] = '{1,  4, 1, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'h0,        16'd1, 1'b0};
        tbl[4] = '{1,  1, 0, 32'h00000000, 32'h00000000, 1'b0, 32'h0,        16'd1, 1'b1};
        tbl[5] = '{2,  9, 0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h0,        16'd2, 1'b1};
        tbl[6] = '{2, 16, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h0,        16'd2, 1'b0};
        tbl[7] = '{1,  8, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        16'd2, 1'b0};

        for (int i = 0; i < NI; i++) begin
            s_valid_a[i]   = 1'b0;
            s_data_a[i]    = 8'h00;
            s_last_a[i]    = 1'b0;
            res_ready_a[i] = 1'b0;
            seed_a[i]      = 32'h0;
            fxor_a[i]      = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_res_valid", 64'(res_valid_w[i]), 64'd0);
            chk("rst_res_crc", 64'(res_crc_w[i]), 64'd0);
            chk("rst_res_words", 64'(res_words_w[i]), 64'd0);
            chk("rst_res_len_err", 64'(res_err_w[i]), 64'd0);
            chk("rst_eng_enable", 64'(eng_en_w[i]), 64'd0);
            chk("rst_eng_crc_in", 64'(eng_cin_w[i]), 64'd0);
            chk("rst_eng_data", eng_data_w[i], 64'd0);
            chk("rst_s_ready", 64'(s_ready_w[i]), 64'd1);
        end
        @(posedge clk);
        #1;

        // Table-driven frames.
        for (int t = 0; t < 8; t++) begin
            frame_q.delete();
            for (int i = 0; i < tbl[t].len; i++) begin
                frame_q.push_back(tbl[t].pat == 0 ? 8'(8'h31 + i) : 8'(8'h11 * (i + 1)));
            end
            k = tbl[t].inst;
            send_frame(k, tbl[t].seed, tbl[t].fx, 1'b0);
            get_result(k, 0, rc, rw, re);
            model(db_of(k), tbl[t].seed, tbl[t].fx, ec, ew, ee);
            chk("tbl_crc", 64'(rc), tbl[t].known ? 64'(tbl[t].exp_crc) : 64'(ec));
            chk("tbl_words", 64'(rw), 64'(tbl[t].exp_words));
            chk("tbl_len_err", 64'(re), 64'(tbl[t].exp_err));
        end

        // Short final word: padded second word on the 4-byte instance.
        frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        n0 = g_dut[1].issue_cnt;
        check_frame(1, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
        chk("short_issue_count", 64'(g_dut[1].issue_cnt - n0), 64'd2);
        chk("short_eng_data", g_dut[1].last_data, 64'h55000000);

        // Result backpressure with a byte offered (and stalled) meanwhile.
        frame_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        model(4, 32'hFFFFFFFF, 32'hFFFFFFFF, ec, ew, ee);
        wait_valid(1);
        s_valid_a[1] = 1'b1;
        s_data_a[1]  = 8'hAA;
        s_last_a[1]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", 64'(res_valid_w[1]), 64'd1);
            chk("bp_res_crc", 64'(res_crc_w[1]), 64'(ec));
            chk("bp_s_ready", 64'(s_ready_w[1]), 64'd0);
            @(negedge clk);
        end
        res_ready_a[1] = 1'b1;
        @(posedge clk);
        #1;
        res_ready_a[1] = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", 64'(res_valid_w[1]), 64'd0);
        chk("bp_release_s_ready", 64'(s_ready_w[1]), 64'd1);
        chk("bp_crc_held", 64'(res_crc_w[1]), 64'(ec));
        @(posedge clk);
        #1;
        s_valid_a[1] = 1'b0;
        s_last_a[1]  = 1'b0;
        frame_q = '{8'hAA};
        get_result(1, 0, rc, rw, re);
        model(4, 32'hFFFFFFFF, 32'hFFFFFFFF, ec, ew, ee);
        chk("stalled_byte_crc", 64'(rc), 64'(ec));
        chk("stalled_byte_words", 64'(rw), 64'd1);
        chk("stalled_byte_len_err", 64'(re), 64'd1);

        // Reset mid-frame on the 8-byte instance.
        seed_a[2] = 32'hFFFFFFFF;
        fxor_a[2] = 32'h0;
        for (int i = 0; i < 3; i++) put_byte(2, 8'($urandom), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_res_valid", 64'(res_valid_w[2]), 64'd0);
        chk("abort_eng_enable", 64'(eng_en_w[2]), 64'd0);
        chk("abort_s_ready", 64'(s_ready_w[2]), 64'd1);
        @(posedge clk);
        #1;
        frame_q.delete();
        for (int i = 0; i < 8; i++) frame_q.push_back(8'($urandom));
        check_frame(2, 32'hFFFFFFFF, 32'h0, 1'b0, 0);

        // Continuous input: two full words, issues 10 cycles apart.
        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back(8'($urandom));
        seed = $urandom;
        n0 = g_dut[2].issue_cnt;
        check_frame(2, seed, 32'hFFFFFFFF, 1'b0, 0);
        c = seed;
        for (int i = 0; i < 8; i++) c = crc_byte(c, frame_q[i]);
        chk("cont_issue_count", 64'(g_dut[2].issue_cnt - n0), 64'd2);
        chk("cont_issue_spacing", 64'(g_dut[2].last_cyc - g_dut[2].prev_cyc), 64'd10);
        chk("cont_chain_engine", 64'(g_dut[2].last_cin), 64'(g_dut[2].out_at_issue));
        chk("cont_chain_model", 64'(g_dut[2].last_cin), 64'(c));

        // Randomized frames on all instances.
        for (int r = 0; r < 30; r++) begin
            k   = $urandom_range(0, NI - 1);
            len = $urandom_range(1, 20);
            seed = $urandom;
            fx   = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'($urandom);
            frame_q.delete();
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            check_frame(k, seed, fx, 1'b1, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crc_stream_sequencer.md
Name: crc_stream_sequencer

Overview:
- Upstream feeder for the parallel CRC engine.
- Accepts a byte stream (valid/ready/last) and packs bytes into DATA_BYTES-wide words, first byte in the most-significant lane.
- Issues each word to the engine with the running CRC as seed, captures the engine's registered result, and chains it into the next word.
- At end of frame, applies the final XOR and presents the frame CRC on a valid/ready result port.

Parameters:
- DATA_BYTES, 8, bytes per engine word; must match the engine.
- CRC_WIDTH, 32, CRC width; must match the engine.
- CNT_WIDTH, 16, width of the issued-word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid&s_ready
- s_data  in  8  input byte
- s_last  in  1  marks final byte of frame
- crc_seed  in  CRC_WIDTH  initial CRC; sampled on the first accepted byte of a frame
- final_xor  in  CRC_WIDTH  output XOR value; sampled with crc_seed
- eng_data  out  DATA_BYTES*8  packed word to engine data_in
- eng_crc_in  out  CRC_WIDTH  running CRC to engine crc_in
- eng_enable  out  1  engine enable; one-cycle pulse per word
- eng_crc_out  in  CRC_WIDTH  engine registered result
- res_valid  out  1  frame result valid
- res_ready  in  1  result consumed when res_valid&res_ready
- res_crc  out  CRC_WIDTH  final frame CRC
- res_len_err  out  1  frame byte count was not a multiple of DATA_BYTES
- res_words  out  CNT_WIDTH  words issued for the frame; saturates at all-ones

Behaviour:
- Integration: engine final_xor_val=0, reflect_out=0; engine reflect_in is driven externally and is static per frame.
- Reset: state IDLE. eng_data=0, eng_crc_in=0, eng_enable=0, res_valid=0, res_crc=0, res_len_err=0, res_words=0; internal lane count and running CRC are 0.
- Reset mid-frame: aborts the frame with no result. s_ready=1 on the first cycle after rst deasserts.
- s_ready is combinational: 1 only in IDLE and FILL.
- IDLE:
  - On accept: running_crc<=crc_seed, xor_reg<=final_xor, words<=0.
  - Byte goes into lane DATA_BYTES-1 (bits [DATA_BYTES*8-1 -: 8]); lanes below are cleared; count<=1.
  - Next state is ISSUE if count reaches DATA_BYTES or s_last=1, else FILL.
- FILL:
  - Each accepted byte goes into the next lower lane; count++.
  - Go to ISSUE when count reaches DATA_BYTES or on s_last.
- Short word on s_last:
  - Unfilled lanes are zero-padded.
  - len_err<=1 if the final count != DATA_BYTES.
  - Padding is a decided behaviour, not a fault.
- ISSUE (1 cycle):
  - eng_enable=1; eng_data=packed word; eng_crc_in=running_crc.
  - words++ (saturating). Next state WAIT.
- WAIT (1 cycle):
  - eng_enable=0; eng_crc_out now holds the word result.
  - running_crc<=eng_crc_out.
  - Next state DONE if the frame's last byte was seen, else FILL with count=0 and lanes cleared.
- DONE:
  - On entry (registered): res_crc=running_crc^xor_reg, res_len_err, res_words; res_valid=1.
  - Outputs are held stable while res_ready=0.
  - On res_valid&res_ready: res_valid<=0, len_err<=0, go to IDLE.
  - res_crc, res_len_err and res_words keep their last values until the next frame completes.
- Throughput: DATA_BYTES+2 cycles per full word with continuous input.
- Latency: last byte accepted to res_valid high is 3 cycles (ISSUE, WAIT, DONE entry).
- Bytes offered outside IDLE/FILL are stalled, never dropped.
- s_last on the byte that exactly fills a word: no error and no extra word.
- A frame of one byte is legal: one padded word, len_err=1 when DATA_BYTES>1.

Optional Feature:
- Macro: CRC_SEQ_REFLECT_OUT_EN.
- When defined:
  - Adds input port reflect_out (1 bit), sampled with crc_seed.
  - If set, res_crc = bit-reverse(running_crc) ^ xor_reg, where bit i takes bit CRC_WIDTH-1-i.
- When undefined: no port; res_crc is never reflected.

Test Plan:
- CRC-32 frame check: engine poly 0x04C11DB7, reflect_in=0; DATA_BYTES=1, seed 0xFFFFFFFF, final_xor 0.
  - Send ASCII "123456789" with last on '9' -> res_crc=0x0376E6E7, res_words=9, res_len_err=0.
- Final XOR: same as above with final_xor=0xFFFFFFFF -> res_crc=0xFC891918.
- Short final word: DATA_BYTES=4, bytes 0x11,0x22,0x33,0x44,0x55 with last.
  - Second word issued as eng_data=0x55000000; res_words=2, res_len_err=1.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid.
  - res_valid and res_crc are stable; s_ready=0 throughout.
  - res_ready=1 for one cycle -> res_valid=0 and s_ready=1 on the next cycle.
- Reset mid-frame: assert rst after 3 bytes of an 8-byte word.
  - Next cycle: res_valid=0, eng_enable=0, s_ready=1.
  - A fresh 8-byte frame then yields the same CRC as with no aborted prefix.
- Continuous input: DATA_BYTES=8, 16 bytes with s_valid held high.
  - eng_enable pulses exactly twice, 10 cycles apart.
  - eng_crc_in on the second pulse equals eng_crc_out captured in the first WAIT.
